// File: rtl/vrf_pkg.sv
// Shared defaults, FSM state encoding and the per-bit lane-merge helper for the vector register file.
// Pure declarations; no logic or latency of its own.
package vrf_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_LANES    = 8;
  localparam int DEF_LANE_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vrf_state_t;

  // Selects the new bit when its lane is enabled, otherwise keeps the stored bit.
  function automatic logic lane_merge_bit(input logic old_b, input logic new_b, input logic lane_en);
    return lane_en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/vrf_lane_merge.sv
// Combinational per-lane merge of a stored vector with incoming write data under a lane mask.
// Zero latency; one instance feeds both the storage write and the read bypass.
module vrf_lane_merge
  import vrf_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANES*LANE_W-1:0] i_old,
  input  logic [LANES*LANE_W-1:0] i_new,
  input  logic [LANES-1:0]        i_mask,
  output logic [LANES*LANE_W-1:0] o_merged
);

  always_comb begin
    o_merged = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < LANE_W; b++) begin
        o_merged[l*LANE_W + b] = lane_merge_bit(i_old[l*LANE_W + b], i_new[l*LANE_W + b], i_mask[l]);
      end
    end
  end

endmodule

// File: rtl/vector_regfile.sv
// Two-read/one-write vector register file with lane-masked writes, pending-bit scoreboard and bulk clear.
// Reads land one cycle after rd_en; while busy (bulk clear) all requests are ignored and outputs hold.
module vector_regfile
  import vrf_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int LANES    = DEF_LANES,
  parameter  int LANE_W   = DEF_LANE_W,
  localparam int VW       = LANES * LANE_W,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [VW-1:0]     vA,
  output logic [VW-1:0]     vB,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [VW-1:0]     wr_data,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              clr_req,
  output logic              busy
);

  logic [VW-1:0]       r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  vrf_state_t          r_state;
  logic [AW-1:0]       r_cnt;
  logic                r_busy;
  logic [VW-1:0]       r_va;
  logic [VW-1:0]       r_vb;
  logic                r_pa;
  logic                r_pb;

  logic                w_idle;
  logic                w_rd_go;
  logic                w_wr_go;
  logic                w_rsv_go;
  logic [VW-1:0]       w_wr_old;
  logic [VW-1:0]       w_wr_new;
  logic                w_byp_a;
  logic                w_byp_b;
  logic [VW-1:0]       w_rd_a_dat;
  logic [VW-1:0]       w_rd_b_dat;
  logic                w_rd_a_pend;
  logic                w_rd_b_pend;

  // A clear request in IDLE swallows any write or reserve presented alongside it.
  assign w_idle   = (r_state == IDLE);
  assign w_rd_go  = w_idle & rd_en;
  assign w_wr_go  = w_idle & wr_en & ~clr_req;
  assign w_rsv_go = w_idle & rsv_en & ~clr_req;

  assign w_wr_old = r_mem[wr_addr];

  vrf_lane_merge #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_merge (
    .i_old    (w_wr_old),
    .i_new    (wr_data),
    .i_mask   (wr_mask),
    .o_merged (w_wr_new)
  );

  // A write landing this edge forwards its merged value and reports the register as no longer pending.
  assign w_byp_a     = w_wr_go & (wr_addr == rd_addr_a);
  assign w_byp_b     = w_wr_go & (wr_addr == rd_addr_b);
  assign w_rd_a_dat  = w_byp_a ? w_wr_new : r_mem[rd_addr_a];
  assign w_rd_b_dat  = w_byp_b ? w_wr_new : r_mem[rd_addr_b];
  assign w_rd_a_pend = ~w_byp_a & r_pend[rd_addr_a];
  assign w_rd_b_pend = ~w_byp_b & r_pend[rd_addr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_va    <= '0;
      r_vb    <= '0;
      r_pa    <= 1'b0;
      r_pb    <= 1'b0;
      r_pend  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_rd_go) begin
        r_va <= w_rd_a_dat;
        r_vb <= w_rd_b_dat;
        r_pa <= w_rd_a_pend;
        r_pb <= w_rd_b_pend;
      end

      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
          if (w_wr_go) begin
            r_mem[wr_addr]  <= w_wr_new;
            r_pend[wr_addr] <= 1'b0;
          end
          // Later assignment wins, so a same-cycle reserve leaves the bit set.
          if (w_rsv_go) begin
            r_pend[rsv_addr] <= 1'b1;
          end
        end
        CLEAR: begin
          r_mem[r_cnt]  <= '0;
          r_pend[r_cnt] <= 1'b0;
          if (r_cnt == AW'(NUM_REGS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign vA     = r_va;
  assign vB     = r_vb;
  assign pend_a = r_pa;
  assign pend_b = r_pb;
  assign busy   = r_busy;

endmodule

// File: tb/tb_vector_regfile.sv
// Directed bench for vector_regfile: a register-array model checked every cycle, plus literal spot checks.
module tb_vector_regfile;

  localparam int NR = 8;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [63:0] vA;
  logic [63:0] vB;
  logic        pend_a;
  logic        pend_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic        clr_req;
  logic        busy;

  vector_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .vA        (vA),
    .vB        (vB),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: plain array of register values, pending flags and a count of clear cycles still to run.
  logic [63:0] m_mem [NR];
  logic [7:0]  m_pend;
  int          m_clear_left;
  logic [63:0] e_va, e_vb;
  logic        e_pa, e_pb;
  bit          m_valid = 0;
  logic [63:0] m_merged;
  bit          m_wr_ok;
  int          m_idx;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_pend = '0;
      m_clear_left = 0;
      e_va = '0; e_vb = '0; e_pa = 0; e_pb = 0;
      m_valid = 1;
    end else if (m_clear_left > 0) begin
      m_idx = NR - m_clear_left;
      m_mem[m_idx] = '0;
      m_pend[m_idx] = 1'b0;
      m_clear_left--;
    end else begin
      m_merged = m_mem[wr_addr];
      for (int l = 0; l < 8; l++)
        if (wr_mask[l]) m_merged[l*8 +: 8] = wr_data[l*8 +: 8];
      m_wr_ok = wr_en && !clr_req;
      if (rd_en) begin
        if (m_wr_ok && wr_addr == rd_addr_a) begin e_va = m_merged; e_pa = 0; end
        else begin e_va = m_mem[rd_addr_a]; e_pa = m_pend[rd_addr_a]; end
        if (m_wr_ok && wr_addr == rd_addr_b) begin e_vb = m_merged; e_pb = 0; end
        else begin e_vb = m_mem[rd_addr_b]; e_pb = m_pend[rd_addr_b]; end
      end
      if (clr_req) begin
        m_clear_left = NR;
      end else begin
        if (wr_en) begin m_mem[wr_addr] = m_merged; m_pend[wr_addr] = 1'b0; end
        if (rsv_en) m_pend[rsv_addr] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("vA", vA, e_va);
      chk("vB", vB, e_vb);
      chk("pend_a", 64'(pend_a), 64'(e_pa));
      chk("pend_b", 64'(pend_b), 64'(e_pb));
      chk("busy", 64'(busy), 64'(m_clear_left > 0));
    end
  end

  task automatic idle();
    rd_en = 0; rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d, input logic [7:0] m);
    wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    rd_en = 1; rd_addr_a = a; rd_addr_b = b;
  endtask

  int nbusy;

  initial begin
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("rst_vA", vA, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    for (int i = 0; i < NR; i++) begin
      idle(); rd(3'(i), 3'(NR - 1 - i)); cyc();
      chk("init_vA", vA, 64'h0);
      chk("init_vB", vB, 64'h0);
      chk("init_pend_a", 64'(pend_a), 64'h0);
    end

    idle(); wr(3, 64'h1122334455667788, 8'hFF); cyc();
    idle(); wr(3, 64'hAAAAAAAAAAAAAAAA, 8'h0F); cyc();
    idle(); rd(3, 3); cyc();
    chk("mask_vA", vA, 64'h11223344AAAAAAAA);
    chk("mask_vB", vB, 64'h11223344AAAAAAAA);

    idle(); wr(5, 64'hDEADBEEF00000000, 8'hF0); rd(5, 5); cyc();
    chk("byp_vA", vA, 64'hDEADBEEF00000000);
    chk("byp_vB", vB, 64'hDEADBEEF00000000);

    idle(); rsv_en = 1; rsv_addr = 2; cyc();
    idle(); rd(2, 0); cyc();
    chk("rsv_pend", 64'(pend_a), 64'h1);
    idle(); wr(2, 64'hFFFFFFFFFFFFFFFF, 8'h00); cyc();
    idle(); rd(2, 0); cyc();
    chk("m0_pend", 64'(pend_a), 64'h0);
    chk("m0_data", vA, 64'h0);
    idle(); wr(2, 64'h0123, 8'hFF); rsv_en = 1; rsv_addr = 2; cyc();
    idle(); rd(2, 2); cyc();
    chk("rsvwin_a", 64'(pend_a), 64'h1);
    chk("rsvwin_b", 64'(pend_b), 64'h1);

    for (int i = 0; i < NR; i++) begin
      idle(); wr(3'(i), {8{8'(i + 1)}}, 8'hFF); cyc();
    end
    idle(); rd(1, 7); cyc();
    chk("fill_r1", vA, 64'h0202020202020202);
    chk("fill_r7", vB, 64'h0808080808080808);

    idle(); clr_req = 1; wr(1, 64'hFFFFFFFFFFFFFFFF, 8'hFF); rsv_en = 1; rsv_addr = 1; cyc();
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy === 1'b1) nbusy++;
      idle();
      if (k < 4) begin
        rd(6, 1); wr(6, 64'hFFFFFFFFFFFFFFFF, 8'hFF); rsv_en = 1; rsv_addr = 6; clr_req = 1;
      end
      cyc();
    end
    chk("busy_cycles", 64'(nbusy), 64'd8);
    for (int i = 0; i < NR; i++) begin
      idle(); rd(3'(i), 3'(i)); cyc();
      chk("clr_data", vA, 64'h0);
      chk("clr_pend", 64'(pend_a), 64'h0);
    end

    idle(); wr(4, 64'h4444444444444444, 8'hFF); rsv_en = 1; rsv_addr = 6; cyc();
    idle(); clr_req = 1; cyc();
    idle(); cyc(); cyc();
    rst = 1; cyc();
    rst = 0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_vA", vA, 64'h0);
    idle(); rd(4, 6); cyc();
    chk("abort_r4", vA, 64'h0);
    chk("abort_r6_pend", 64'(pend_b), 64'h0);
    idle(); wr(7, 64'hAB112233445566CD, 8'h81); cyc();
    idle(); rd(7, 4); cyc();
    chk("post_r7", vA, 64'hAB000000000000CD);

    idle(); cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
